sdram_stream_reader: RTL

- Read-side DMA engine for the sample SDRAM.
- Streams a CPU-programmed range of 16-bit SDRAM words out as a byte stream: low byte first, valid/ready handshake, toward the USB IN data path.
- It is the reader counterpart of the sample-capture DMA writer.
- Sits on clk_48 between the sdram controller's read channel (araddr/arvalid/arready, rdata/rvalid) and the USB endpoint buffer filler.

---
 rtl/sdram_stream_reader_if.sv | 31 +++
 rtl/sdram_stream_reader.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sdram_stream_reader_if.sv
// rtl/sdram_stream_reader_if.sv - control, SDRAM read channel and byte stream bundle for sdram_stream_reader
interface sdram_stream_reader_if #(
    parameter int AW = 24,
    parameter int CW = 24
);
    logic          start;
    logic [AW-1:0] start_addr;
    logic [CW-1:0] word_count;
    logic          abort;
    logic          busy;
    logic          done;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [15:0]   rdata;
    logic          rvalid;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   stall_cycles;

    modport master (
        input  start, start_addr, word_count, abort, arready, rdata, rvalid, out_ready,
        output busy, done, araddr, arvalid, out_data, out_valid, stall_cycles
    );

    modport slave (
        output start, start_addr, word_count, abort, arready, rdata, rvalid, out_ready,
        input  busy, done, araddr, arvalid, out_data, out_valid, stall_cycles
    );
endinterface

// File: rtl/sdram_stream_reader.sv
// rtl/sdram_stream_reader.sv - SDRAM word range to byte stream DMA reader (option: SDRAM_STREAM_READER_STATS_EN)
module sdram_stream_reader #(
    parameter int AW        = 24,
    parameter int CW        = 24,
    parameter int FIFO_LOG2 = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    sdram_stream_reader_if.master bus
);
    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam logic [FIFO_LOG2+1:0] DEPTH_W = (FIFO_LOG2+2)'(DEPTH);
    localparam logic [FIFO_LOG2:0]   CNT_ONE = (FIFO_LOG2+1)'(1);
    localparam logic [FIFO_LOG2-1:0] PTR_ONE = FIFO_LOG2'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;
    state_t state, state_nxt;

    logic [AW-1:0]        addr;
    logic [CW-1:0]        to_issue;
    logic [FIFO_LOG2:0]   outstanding;
    logic [FIFO_LOG2:0]   count;
    logic [FIFO_LOG2-1:0] rd_ptr;
    logic [FIFO_LOG2-1:0] wr_ptr;
    logic [15:0]          mem [DEPTH];
    logic                 phase;
    logic [7:0]           out_data_r;
    logic                 out_valid_r;

    logic                 start_ok, abort_ok, ar_ok, issue, ret, push, pop, fire, load_low, drained;
    logic [FIFO_LOG2+1:0] credit_used;
    logic [FIFO_LOG2:0]   avail;
    logic [FIFO_LOG2-1:0] cand_ptr;
    logic [7:0]           cand_low;

    // Requests are only issued while every returning word is guaranteed a FIFO slot,
    // since the read channel cannot be stalled.
    assign credit_used = {1'b0, count} + {1'b0, outstanding};
    assign ar_ok       = (state == S_RUN) && (to_issue != '0) && (credit_used < DEPTH_W);
    assign start_ok    = bus.start && (state == S_IDLE);
    assign abort_ok    = bus.abort && (state == S_RUN);
    assign issue       = ar_ok && bus.arready;
    assign ret         = bus.rvalid && (outstanding != '0) && ((state == S_RUN) || (state == S_FLUSH));
    assign push        = ret && (state == S_RUN) && !bus.abort;
    assign fire        = out_valid_r && bus.out_ready;
    assign pop         = fire && phase;
    // Next low byte comes from the word behind the one being popped, or straight
    // from rdata when the FIFO has nothing else, giving one-cycle latency.
    assign avail       = count - (FIFO_LOG2+1)'(pop);
    assign cand_ptr    = rd_ptr + FIFO_LOG2'(pop);
    assign cand_low    = (avail != '0) ? mem[cand_ptr][7:0] : bus.rdata[7:0];
    assign load_low    = (!out_valid_r || pop) && ((avail != '0) || push);
    assign drained     = (to_issue == '0) && (outstanding == '0) && (count == '0) && !out_valid_r;

`ifdef SDRAM_STREAM_READER_STATS_EN
    logic [15:0] stall_cnt;

    // Count back-pressured byte cycles, restarting with each accepted transfer
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            stall_cnt <= '0;
        end else if (out_valid_r && !bus.out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and control outputs; abort takes priority over completion
    always_comb begin
        state_nxt        = state;
        bus.busy         = (state != S_IDLE);
        bus.done         = (state == S_DONE);
        bus.arvalid      = ar_ok;
        bus.araddr       = addr;
        bus.out_data     = out_data_r;
        bus.out_valid    = out_valid_r;
        bus.stall_cycles = '0;
`ifdef SDRAM_STREAM_READER_STATS_EN
        bus.stall_cycles = stall_cnt;
`endif
        case (state)
            S_IDLE:  if (bus.start) state_nxt = (bus.word_count == '0) ? S_DONE : S_RUN;
            S_RUN: begin
                if (bus.abort) begin
                    state_nxt = S_FLUSH;
                end else if (drained) begin
                    state_nxt = S_DONE;
                end
            end
            S_FLUSH: if (outstanding == '0) state_nxt = S_IDLE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request address, words left to request, and reads in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            addr        <= '0;
            to_issue    <= '0;
            outstanding <= '0;
        end else begin
            if (start_ok) begin
                addr     <= bus.start_addr;
                to_issue <= bus.word_count;
            end else if (issue) begin
                addr     <= addr + AW'(1);
                to_issue <= to_issue - CW'(1);
            end
            if (issue && !ret) begin
                outstanding <= outstanding + CNT_ONE;
            end else if (!issue && ret) begin
                outstanding <= outstanding - CNT_ONE;
            end
        end
    end

    // Word FIFO storage
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.rdata;
        end
    end

    // FIFO pointers and registered byte output; the head word leaves on its high-byte handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            phase       <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else if (abort_ok) begin
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            phase       <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (!push && pop) begin
                count <= count - CNT_ONE;
            end
            if (fire && !phase) begin
                out_data_r <= mem[rd_ptr][15:8];
                phase      <= 1'b1;
            end else if (load_low) begin
                out_data_r  <= cand_low;
                out_valid_r <= 1'b1;
                phase       <= 1'b0;
            end else if (pop) begin
                out_valid_r <= 1'b0;
                phase       <= 1'b0;
            end
        end
    end
endmodule
